// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-serial program loader and instruction-fetch responder
//
// Loads a little-endian byte stream into a byte-wide instruction store while
// holding the core, pads an unaligned tail with zero bytes, then releases the
// core and serves 32-bit instruction words combinationally from the PC.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   load_valid in   load_byte valid this cycle
//   load_byte  in   next program byte, ascending address order
//   load_last  in   accepted byte is the final one
//   load_ready out  loader accepts a byte this cycle (LOAD state)
//   count      in   PC byte address from the core
//   data_out   out  instruction word at count (NOP_WORD when masked)
//   cpu_hold   out  core held while not in RUN
//   load_done  out  high in RUN
//   load_err   out  sticky overflow flag
//   load_len   out  number of valid bytes, 0..MEM_BYTES

module instr_mem_loader #(
  parameter int          MEM_BYTES = 4096,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] count,
  output logic [31:0]       data_out,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_len
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PAD  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEN_WORD = (ADDR_W + 1)'(4);
  localparam logic [ADDR_W-1:0] A_ONE    = (ADDR_W)'(1);
  localparam logic [ADDR_W-1:0] A_TWO    = (ADDR_W)'(2);
  localparam logic [ADDR_W-1:0] A_THREE  = (ADDR_W)'(3);

  state_t            state, state_nx;
  logic [ADDR_W:0]   len_q, len_nx, len_inc;
  logic              err_q, err_nx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  logic [7:0] mem [MEM_BYTES];

  assign len_inc = len_q + LEN_ONE;

  // Next-state, length, error and store-write control.
  always_comb begin
    state_nx  = state;
    len_nx    = len_q;
    err_nx    = err_q;
    mem_we    = 1'b0;
    mem_waddr = len_q[ADDR_W-1:0];
    mem_wdata = load_byte;
    case (state)
      S_LOAD: begin
        if (load_valid) begin
          if (len_q != LEN_FULL) begin
            mem_we = 1'b1;
            len_nx = len_inc;
          end else begin
            err_nx = 1'b1;
          end
          // A full store is word aligned, so the low-bit test also covers
          // the overflow case where the final byte was dropped.
          if (load_last) begin
            if (len_nx[1:0] == 2'b00) begin
              state_nx = S_RUN;
            end else begin
              state_nx = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        mem_we    = 1'b1;
        mem_wdata = 8'h00;
        len_nx    = len_inc;
        if (len_inc[1:0] == 2'b00) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        state_nx = S_RUN;
      end
      default: begin
        state_nx = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      len_q <= len_nx;
      err_q <= err_nx;
    end
  end

  // Store is not cleared on reset; the length mask hides stale contents.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Combinational fetch with 12-bit address wrap.
  logic [ADDR_W-1:0] rd_a0, rd_a1, rd_a2, rd_a3;
  logic [31:0]       rd_word;
  logic              rd_in_range;

  assign rd_a0   = count;
  assign rd_a1   = count + A_ONE;
  assign rd_a2   = count + A_TWO;
  assign rd_a3   = count + A_THREE;
  assign rd_word = {mem[rd_a3], mem[rd_a2], mem[rd_a1], mem[rd_a0]};

  assign rd_in_range = (len_q == LEN_FULL) || (({1'b0, count} + LEN_WORD) <= len_q);

  assign data_out   = ((state == S_RUN) && rd_in_range) ? rd_word : NOP_WORD;
  assign load_ready = (state == S_LOAD);
  assign cpu_hold   = (state != S_RUN);
  assign load_done  = (state == S_RUN);
  assign load_err   = err_q;
  assign load_len   = len_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed scoreboard bench for instr_mem_loader

module tb_instr_mem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic [11:0] count;
  logic [31:0] data_out;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [12:0] load_len;

  instr_mem_loader #(
    .MEM_BYTES(4096),
    .ADDR_W   (12),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_byte (load_byte),
    .load_last (load_last),
    .load_ready(load_ready),
    .count     (count),
    .data_out  (data_out),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .load_len  (load_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] word;
  } rd_t;

  rd_t        sb[$];
  logic [7:0] mmem [4096];
  int         mlen;
  bit         mrun;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit with_byte);
    reset      = 1'b1;
    load_valid = with_byte;
    load_byte  = 8'h99;
    load_last  = 1'b0;
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    mlen       = 0;
    mrun       = 1'b0;
    count      = 12'd0;
    #1;
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_hold",  32'(cpu_hold),   32'd1);
    check("rst_done",  32'(load_done),  32'd0);
    check("rst_err",   32'(load_err),   32'd0);
    check("rst_len",   32'(load_len),   32'd0);
    check("rst_data",  data_out,        NOP);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = 8'hEE;
    if (mlen < 4096) begin
      mmem[mlen] = b;
      mlen++;
    end
    if (last) begin
      while ((mlen % 4) != 0) begin
        mmem[mlen] = 8'h00;
        mlen++;
      end
      mrun = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [11:0] a);
    logic [11:0] a1, a2, a3;
    a1 = a + 12'd1;
    a2 = a + 12'd2;
    a3 = a + 12'd3;
    if (!mrun) return NOP;
    if (mlen != 4096 && (int'(a) + 4) > mlen) return NOP;
    return {mmem[a3], mmem[a2], mmem[a1], mmem[a]};
  endfunction

  task automatic push(input logic [11:0] a, input logic [31:0] w);
    rd_t r;
    r.addr = a;
    r.word = w;
    sb.push_back(r);
  endtask

  task automatic drain();
    rd_t r;
    while (sb.size() > 0) begin
      r     = sb.pop_front();
      count = r.addr;
      #1;
      check($sformatf("rd@%0d", r.addr), data_out, r.word);
    end
  endtask

  initial begin
    logic [7:0] prog [8];
    int         gap;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    load_last  = 1'b0;
    count      = 12'd0;
    mlen       = 0;
    mrun       = 1'b0;

    // Aligned load
    do_reset(1'b0);
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], i == 7);
      if (i == 6) begin
        check("al_hold_pre", 32'(cpu_hold), 32'd1);
        check("al_data_pre", data_out, NOP);
        check("al_len_pre",  32'(load_len), 32'd7);
      end
    end
    check("al_done", 32'(load_done), 32'd1);
    check("al_hold", 32'(cpu_hold),  32'd0);
    check("al_len",  32'(load_len),  32'd8);
    check("al_rdy",  32'(load_ready), 32'd0);
    push(12'd0, 32'h00000013);
    push(12'd4, 32'h00500093);
    push(12'd8, NOP);
    push(12'd5, exp_word(12'd5));
    drain();

    // Unaligned load with padding
    do_reset(1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pad_rdy%0d", i),  32'(load_ready), 32'd0);
      check($sformatf("pad_hold%0d", i), 32'(cpu_hold),   32'd1);
      check($sformatf("pad_len%0d", i),  32'(load_len),   32'(5 + i));
      tick();
    end
    check("pad_done", 32'(load_done), 32'd1);
    check("pad_len",  32'(load_len),  32'd8);
    push(12'd4, 32'h000000AA);
    push(12'd0, 32'h04030201);
    push(12'd8, NOP);
    drain();

    // Backpressure and gaps
    do_reset(1'b0);
    count = 12'd0;
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        load_byte = 8'hEE;
        tick();
        check("bp_hold", 32'(cpu_hold), 32'd1);
        check("bp_data", data_out, NOP);
      end
      send_byte(8'h30 + 8'(i), i == 11);
      if (i < 11) begin
        check("bp_hold_b", 32'(cpu_hold), 32'd1);
        check("bp_data_b", data_out, NOP);
      end
    end
    check("bp_hold_end", 32'(cpu_hold), 32'd0);
    check("bp_len",      32'(load_len), 32'd12);
    push(12'd0, 32'h33323130);
    push(12'd4, exp_word(12'd4));
    push(12'd8, 32'h3B3A3938);
    push(12'd9, NOP);
    push(12'd12, NOP);
    drain();

    // Overflow and wrap-around read
    do_reset(1'b0);
    for (int i = 0; i <= 4096; i++) begin
      send_byte(i[7:0], i == 4096);
      if (i == 4095) begin
        check("ov_len_full", 32'(load_len), 32'd4096);
        check("ov_err_pre",  32'(load_err), 32'd0);
        check("ov_rdy_pre",  32'(load_ready), 32'd1);
      end
    end
    check("ov_err",  32'(load_err),  32'd1);
    check("ov_len",  32'(load_len),  32'd4096);
    check("ov_done", 32'(load_done), 32'd1);
    push(12'd4092, 32'hFFFEFDFC);
    push(12'd4094, 32'h0100FFFE);
    push(12'd0,    32'h03020100);
    push(12'd4095, exp_word(12'd4095));
    drain();
    tick();
    check("ov_err_sticky", 32'(load_err), 32'd1);

    // Mid-load reset (reset from RUN first, then abandon a partial load)
    do_reset(1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'hEF, 1'b0);
    check("ml_len_pre", 32'(load_len), 32'd3);
    do_reset(1'b1);
    prog[0] = 8'h13;
    prog[1] = 8'h00;
    prog[2] = 8'h00;
    prog[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      send_byte(prog[i], i == 3);
    end
    check("ml_len",  32'(load_len),  32'd4);
    check("ml_done", 32'(load_done), 32'd1);
    push(12'd0, 32'h00000013);
    push(12'd4, NOP);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-serial program loader and instruction-fetch responder for the `sistem` core. During load it accepts a little-endian byte stream into a 4096-byte instruction store and holds the CPU. It then releases the CPU and answers every 12-bit `count` (PC) with the 32-bit instruction word as `data_in`. It is the hardware counterpart of the fetch-side memory: it writes the store that the core's PC reads.

## Interface
Parameters:
- `MEM_BYTES`, 4096: store depth in bytes. Fixed to 2^`ADDR_W`.
- `ADDR_W`, 12: PC/byte address width. Matches `count`.
- `NOP_WORD`, 32'h00000013: word returned for unloaded or masked addresses (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: `load_byte` is valid this cycle.
- `load_byte` in 8: next program byte, in ascending address order.
- `load_last` in 1: qualifies the accepted byte as the final byte. Ignored unless `load_valid && load_ready`.
- `load_ready` out 1: loader accepts a byte this cycle.
- `count` in 12: PC byte address from the core.
- `data_out` out 32: instruction word `{mem[count+3], mem[count+2], mem[count+1], mem[count]}`. Connects to core `data_in`.
- `cpu_hold` out 1: high while loading. Holds the core in reset.
- `load_done` out 1: high in RUN.
- `load_err` out 1: sticky overflow flag.
- `load_len` out 13: number of valid bytes, range 0..4096.

## Operation
- States:
  - LOAD: entered on reset.
  - PAD: entered when the program ends unaligned.
  - RUN: terminal until reset.
- LOAD:
  - `load_ready`=1.
  - On each accepted byte: if `load_len` < 4096, write `mem[load_len[11:0]]` and increment `load_len`.
  - If `load_len` == 4096: drop the byte and set `load_err`.
  - On an accepted byte with `load_last`=1:
    - If the post-increment `load_len[1:0]` == 0, or `load_len` == 4096, go to RUN.
    - Otherwise go to PAD.
- PAD:
  - `load_ready`=0.
  - Each cycle, write 8'h00 at `mem[load_len]` and increment `load_len`.
  - Go to RUN on the cycle that makes `load_len[1:0]` == 0.
- RUN:
  - `cpu_hold`=0, `load_done`=1, `load_ready`=0.
  - `load_valid` and `load_byte` are ignored.
  - Store is read-only.
- Read path is combinational from `count`:
  - Byte addresses are `count+0..3`, computed mod 4096 (12-bit wrap).
  - Masking: `data_out` = `NOP_WORD` if the state is not RUN, or if `load_len` != 4096 and `{1'b0,count}+13'd4` > `load_len`.
  - Otherwise `data_out` is the assembled word.
  - When `load_len` == 4096, nothing is masked and wrap-around words are returned.
- Store memory is not cleared by reset. Stale contents are hidden by the `load_len` mask.
- Reset mid-LOAD or mid-PAD: abandon the load immediately. `load_len`=0, `load_err`=0, state LOAD.
- Reset in RUN: same as above; the core is re-held and a full reload is required.
- Simultaneous `reset` and `load_valid`: reset wins and the byte is not written.

## Timing
- Outputs during and immediately after reset:
  - `load_ready`=1 (state LOAD).
  - `cpu_hold`=1, `load_done`=0, `load_err`=0, `load_len`=0.
  - `data_out`=`NOP_WORD`.
- Byte acceptance:
  - A byte is accepted at edge N when `load_valid && load_ready`.
  - `load_len` updates after edge N.
  - The written byte is readable in RUN only.
- Throughput is one byte per cycle. No bubble between back-to-back bytes.
- `load_last` on an aligned byte at edge N: RUN from cycle N+1, so `cpu_hold` falls and `load_done` rises in the same cycle.
- `load_last` unaligned: PAD lasts `4 - (load_len mod 4)` cycles, then RUN.
- Read latency is zero cycles: `data_out` follows `count` combinationally.
- `load_err` sets in the cycle after the first dropped byte and stays set until reset.

## Test plan
- Aligned load:
  - Stimulus: bytes 13 00 00 00 93 00 50 00, `load_last` on the 8th.
  - Required: RUN the next cycle, `load_len`=8.
  - `count`=0 -> 0x00000013; `count`=4 -> 0x00500093; `count`=8 -> `NOP_WORD`.
- Unaligned load with padding:
  - Stimulus: 5 bytes, the 5th = AA with `load_last`.
  - Required: 3 PAD cycles with `load_ready`=0, then RUN, `load_len`=8, `count`=4 -> 0x000000AA.
- Backpressure and gaps:
  - Stimulus: `load_valid` toggled randomly over 12 bytes.
  - Required: only accepted bytes are stored, in order.
  - `cpu_hold` stays 1 until last + 1; `data_out`=`NOP_WORD` throughout LOAD.
- Overflow:
  - Stimulus: 4097 bytes, byte i = i[7:0], last on the 4097th.
  - Required: `load_err`=1, `load_len`=4096, `count`=4092 -> 0xFFFEFDFC; the 4097th byte is not stored.
- Wrap-around read:
  - Stimulus: after the overflow test, `count`=4094.
  - Required: `data_out` = 0x0100FFFE.
- Mid-load reset:
  - Stimulus: assert `reset` after 3 bytes, then reload 4 bytes 13 00 00 00.
  - Required: `load_len`=0 and `cpu_hold`=1 after reset; after the reload, `count`=0 -> 0x00000013 and `count`=4 -> `NOP_WORD`.
